// File: rtl/i2c_slave_if.sv
// Host-side handshake for the I2C target: read-byte load, write-byte delivery and transaction status.
// Single-cycle pulses on tx_load/rx_valid; there is no backpressure, so the host must act in that cycle.
interface i2c_slave_if;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       rw_dir;
    logic       busy;

    modport slave (
        input  tx_data,
        output tx_load, rx_data, rx_valid, addr_match, rw_dir, busy
    );

    modport master (
        output tx_data,
        input  tx_load, rx_data, rx_valid, addr_match, rw_dir, busy
    );
endinterface

// File: rtl/i2c_slave.sv
// Oversampled I2C target: 7-bit address match, write/read bytes, open-drain ACK; events act 3 clk after the pin edge.
// No clock stretching or backpressure: tx_data must be valid when tx_load pulses, rx_data is consumed on rx_valid.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    i2c_slave_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, ADDRESS, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
    } state_t;

    logic scl_s1, scl_s2, scl_s3;
    logic sda_s1, sda_s2, sda_s3;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       sda_oe, sda_oe_n;
    logic       phase, phase_n;
    logic [7:0] rx_data_q, rx_data_n;
    logic       rx_valid_q, rx_valid_n;
    logic       tx_load_q, tx_load_n;
    logic       addr_match_q, addr_match_n;
    logic       rw_dir_q, rw_dir_n;
    logic       busy_q, busy_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_s3 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_s3 <= 1'b1;
        end else begin
            scl_s1 <= i2c_scl;
            scl_s2 <= scl_s1;
            scl_s3 <= scl_s2;
            sda_s1 <= i2c_sda;
            sda_s2 <= sda_s1;
            sda_s3 <= sda_s2;
        end
    end

    assign scl_rise  =  scl_s2 & ~scl_s3;
    assign scl_fall  = ~scl_s2 &  scl_s3;
    assign start_det =  scl_s2 &  sda_s3 & ~sda_s2;
    assign stop_det  =  scl_s2 & ~sda_s3 &  sda_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= 3'd7;
            shift        <= 8'h00;
            sda_oe       <= 1'b0;
            phase        <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            tx_load_q    <= 1'b0;
            addr_match_q <= 1'b0;
            rw_dir_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            shift        <= shift_n;
            sda_oe       <= sda_oe_n;
            phase        <= phase_n;
            rx_data_q    <= rx_data_n;
            rx_valid_q   <= rx_valid_n;
            tx_load_q    <= tx_load_n;
            addr_match_q <= addr_match_n;
            rw_dir_q     <= rw_dir_n;
            busy_q       <= busy_n;
        end
    end

    // phase splits each ACK slot: 0 = waiting for the fall that starts it, 1 = waiting for the fall that ends it.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        sda_oe_n     = sda_oe;
        phase_n      = phase;
        rx_data_n    = rx_data_q;
        rx_valid_n   = 1'b0;
        tx_load_n    = 1'b0;
        addr_match_n = addr_match_q;
        rw_dir_n     = rw_dir_q;
        busy_n       = busy_q;

        if (start_det) begin
            state_n      = ADDRESS;
            bit_cnt_n    = 3'd7;
            sda_oe_n     = 1'b0;
            busy_n       = 1'b1;
            addr_match_n = 1'b0;
        end else if (stop_det) begin
            state_n      = IDLE;
            sda_oe_n     = 1'b0;
            busy_n       = 1'b0;
            addr_match_n = 1'b0;
        end else begin
            case (state)
                ADDRESS: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_s2};
                        if (bit_cnt == 3'd0) begin
                            if (shift[6:0] == SLAVE_ADDR) begin
                                rw_dir_n     = sda_s2;
                                addr_match_n = 1'b1;
                                phase_n      = 1'b0;
                                state_n      = ADDR_ACK;
                            end else begin
                                sda_oe_n = 1'b0;
                                state_n  = WAIT_STOP;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt - 3'd1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_oe_n = 1'b1;
                            phase_n  = 1'b1;
                            if (rw_dir_q) begin
                                shift_n   = bus.tx_data;
                                tx_load_n = 1'b1;
                            end
                        end else begin
                            bit_cnt_n = 3'd7;
                            if (rw_dir_q) begin
                                sda_oe_n = ~shift[7];
                                state_n  = TX_DATA;
                            end else begin
                                sda_oe_n = 1'b0;
                                state_n  = RX_DATA;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_s2};
                        if (bit_cnt == 3'd0) begin
                            rx_data_n  = {shift[6:0], sda_s2};
                            rx_valid_n = 1'b1;
                            phase_n    = 1'b0;
                            state_n    = RX_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt - 3'd1;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_oe_n = 1'b1;
                            phase_n  = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 3'd7;
                            state_n   = RX_DATA;
                        end
                    end
                end
                TX_DATA: begin
                    // bit_cnt counts bits still to be driven after the one currently on the bus.
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_n = 1'b0;
                            phase_n  = 1'b0;
                            state_n  = TX_ACK;
                        end else begin
                            shift_n   = {shift[6:0], 1'b0};
                            sda_oe_n  = ~shift[6];
                            bit_cnt_n = bit_cnt - 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s2) begin
                            shift_n   = bus.tx_data;
                            tx_load_n = 1'b1;
                            phase_n   = 1'b1;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = WAIT_STOP;
                        end
                    end else if (scl_fall && phase) begin
                        sda_oe_n  = ~shift[7];
                        bit_cnt_n = 3'd7;
                        state_n   = TX_DATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign i2c_sda        = sda_oe ? 1'b0 : 1'bz;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_load    = tx_load_q;
    assign bus.addr_match = addr_match_q;
    assign bus.rw_dir     = rw_dir_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: bit-banged I2C master against the target, immediate-assertion checks.
module tb_i2c_slave;
    localparam int Q = 25;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    int checks = 0;
    int failures = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int both_cnt = 0;
    logic [7:0] rx_log [16];

    always #5 clk = ~clk;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_if bus ();

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk     (clk),
        .reset   (reset),
        .i2c_scl (scl),
        .i2c_sda (sda),
        .bus     (bus)
    );

    always @(posedge clk) begin
        if (bus.rx_valid) begin
            if (rx_cnt < 16) rx_log[rx_cnt] = bus.rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (bus.tx_load) tx_cnt = tx_cnt + 1;
        if (bus.rx_valid && bus.tx_load) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hp(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; hp(Q);
        scl = 1'b1;       hp(Q);
        m_sda_low = 1'b1; hp(Q);
        scl = 1'b0;       hp(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; hp(Q);
        scl = 1'b1;       hp(Q);
        m_sda_low = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b; hp(Q);
        scl = 1'b1;     hp(2*Q);
        scl = 1'b0;     hp(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        m_sda_low = 1'b0; hp(Q);
        scl = 1'b1;       hp(Q);
        ack = sda;        hp(Q);
        scl = 1'b0;       hp(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            hp(Q);
            scl = 1'b1; hp(Q);
            d[i] = sda; hp(Q);
            scl = 1'b0;
        end
        hp(Q/2);
        m_sda_low = ~nack; hp(Q);
        scl = 1'b1;        hp(2*Q);
        scl = 1'b0;        hp(Q);
        m_sda_low = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         rx0, tx0;

        bus.tx_data = 8'h00;
        hp(4);
        reset = 1'b0;
        hp(2);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_addr_match", bus.addr_match, 1'b0);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_pulses", {bus.rx_valid, bus.tx_load}, 2'b00);

        // Reset while the target is driving the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(((8'hA0 >> i) & 8'h01) != 0);
        m_sda_low = 1'b0; hp(Q);
        scl = 1'b1;       hp(Q);
        chk("pre_rst_ack_low", sda, 1'b0);
        reset = 1'b1; hp(4);
        chk("midrst_sda_released", sda, 1'b1);
        reset = 1'b0; hp(1);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_addr_match", bus.addr_match, 1'b0);
        chk("midrst_rx_valid", bus.rx_valid, 1'b0);
        chk("midrst_state_idle", dut.state, 32'd0);
        scl = 1'b0; hp(Q);

        // Single-byte write 0xA5.
        rx0 = rx_cnt;
        i2c_start();
        chk("wr_busy_after_start", bus.busy, 1'b1);
        write_byte(8'hA0, ack);
        chk("wr_addr_ack", ack, 1'b0);
        chk("wr_addr_match", bus.addr_match, 1'b1);
        chk("wr_rw_dir", bus.rw_dir, 1'b0);
        write_byte(8'hA5, ack);
        chk("wr_data_ack", ack, 1'b0);
        chk("wr_rx_count", rx_cnt - rx0, 32'd1);
        chk("wr_rx_data", bus.rx_data, 8'hA5);
        i2c_stop();
        @(posedge clk); @(posedge clk); #1;
        chk("stop_busy_2clk", bus.busy, 1'b1);
        @(posedge clk); #1;
        chk("stop_busy_3clk", bus.busy, 1'b0);
        chk("stop_addr_match", bus.addr_match, 1'b0);
        hp(Q);

        // Wrong address 0x51.
        rx0 = rx_cnt; tx0 = tx_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        chk("bad_addr_nack", ack, 1'b1);
        chk("bad_addr_state", dut.state, 32'd7);
        chk("bad_addr_match", bus.addr_match, 1'b0);
        write_byte(8'h00, ack);
        chk("bad_addr_data_nack", ack, 1'b1);
        chk("bad_addr_pulses", (rx_cnt - rx0) + (tx_cnt - tx0), 32'd0);
        i2c_stop(); hp(Q);

        // Read 0x3C, master NACK.
        tx0 = tx_cnt;
        bus.tx_data = 8'h3C;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rd_addr_ack", ack, 1'b0);
        chk("rd_rw_dir", bus.rw_dir, 1'b1);
        chk("rd_addr_match", bus.addr_match, 1'b1);
        read_byte(1'b1, rd);
        chk("rd_data", rd, 8'h3C);
        chk("rd_tx_load_count", tx_cnt - tx0, 32'd1);
        chk("rd_nack_state", dut.state, 32'd7);
        chk("rd_sda_released", sda, 1'b1);
        i2c_stop(); hp(Q);

        // Three-byte write.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        chk("mw_addr_ack", ack, 1'b0);
        for (int b = 1; b <= 3; b++) begin
            write_byte(b[7:0], ack);
            chk("mw_data_ack", ack, 1'b0);
        end
        chk("mw_rx_count", rx_cnt - rx0, 32'd3);
        chk("mw_byte0", rx_log[rx0], 8'h01);
        chk("mw_byte1", rx_log[rx0+1], 8'h02);
        chk("mw_byte2", rx_log[rx0+2], 8'h03);
        i2c_stop(); hp(Q);

        // Write 0x11, repeated START, read 0xF0.
        rx0 = rx_cnt; tx0 = tx_cnt;
        bus.tx_data = 8'hF0;
        i2c_start();
        write_byte(8'hA0, ack);
        chk("rs_wr_addr_ack", ack, 1'b0);
        write_byte(8'h11, ack);
        chk("rs_wr_data_ack", ack, 1'b0);
        i2c_start();
        chk("rs_busy_after_rstart", bus.busy, 1'b1);
        chk("rs_addr_match_dropped", bus.addr_match, 1'b0);
        chk("rs_state_address", dut.state, 32'd1);
        chk("rs_rx_data", bus.rx_data, 8'h11);
        chk("rs_rx_count", rx_cnt - rx0, 32'd1);
        write_byte(8'hA1, ack);
        chk("rs_rd_addr_ack", ack, 1'b0);
        chk("rs_rd_addr_match", bus.addr_match, 1'b1);
        read_byte(1'b1, rd);
        chk("rs_rd_data", rd, 8'hF0);
        chk("rs_busy_end", bus.busy, 1'b1);
        chk("rs_tx_load_count", tx_cnt - tx0, 32'd1);
        i2c_stop(); hp(Q);
        chk("final_busy", bus.busy, 1'b0);
        chk("never_both_pulses", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the on-FPGA I2C master.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, receives write bytes or returns read bytes, and drives ACK on SDA as open-drain.
- Used as the bench responder for the master and as a standalone register-port target.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target ACKs.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- i2c_scl  in  1  bus clock; no clock stretching
- i2c_sda  inout  1  bus data; open-drain: drives 0 or 'bz only
- tx_data  in  8  byte returned on the next read byte; sampled on tx_load
- tx_load  out  1  1-cycle pulse when tx_data is captured
- rx_data  out  8  last byte received in a write
- rx_valid  out  1  1-cycle pulse when rx_data updates
- addr_match  out  1  high from address ACK until STOP or repeated START
- rw_dir  out  1  R/W bit of the current transaction; 1 = read
- busy  out  1  high from START until STOP

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; SDA released ('bz).
  - rx_data = 0; rx_valid = tx_load = addr_match = rw_dir = busy = 0.
  - Synchronizer flops preset to 1.
- Input synchronisation:
  - SCL and SDA each pass through 2 flops, plus a third flop for edge detection.
  - scl_rise/scl_fall: SCL sync transitions.
  - START: SDA sync falls while SCL sync = 1.
  - STOP: SDA sync rises while SCL sync = 1.
  - Detection latency is 3 clk after the pin edge.
- Bus timing:
  - Data is sampled on scl_rise.
  - SDA drive changes only on scl_fall, so data is never changed while SCL is high.
- States: IDLE, ADDRESS, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- START in any state, including mid-byte:
  - state = ADDRESS; bit counter = 7; SDA released; busy = 1; addr_match = 0.
- STOP in any state:
  - state = IDLE; SDA released; busy = 0; addr_match = 0; no rx_valid pulse for a partial byte.
- ADDRESS:
  - Shift 8 bits, MSB first, on scl_rise.
  - After bit 0: if shift[7:1] == SLAVE_ADDR, then rw_dir = shift[0], addr_match = 1, state = ADDR_ACK. Otherwise state = WAIT_STOP, SDA released.
- ADDR_ACK:
  - On the next scl_fall, drive SDA = 0.
  - If rw_dir = 1, also capture tx_data into the shift register and pulse tx_load.
  - On the following scl_fall (end of ACK clock): rw_dir = 0 goes to RX_DATA with SDA released; rw_dir = 1 goes to TX_DATA and drives shift[7] in the same cycle.
- RX_DATA:
  - Shift 8 bits on scl_rise.
  - On the 8th bit: rx_data = assembled byte and rx_valid pulses in that same clk; state = RX_ACK.
- RX_ACK:
  - Drive SDA = 0 from the next scl_fall to the one after.
  - Then return to RX_DATA with counter = 7.
  - Unlimited bytes per transaction.
- TX_DATA:
  - On each scl_fall, drive the next bit: 0 → SDA = 0, 1 → SDA = 'bz.
  - After the 8th bit's scl_fall, release SDA; state = TX_ACK.
- TX_ACK:
  - Sample SDA on scl_rise.
  - 0 (master ACK): capture tx_data, pulse tx_load; on scl_fall drive the MSB and go to TX_DATA.
  - 1 (NACK): state = WAIT_STOP, SDA released.
- WAIT_STOP: ignore the bus until STOP or START.
- Simultaneous events: START/STOP detection takes priority over any scl edge in the same clk.
- Outputs rx_valid and tx_load are never high in the same cycle.

Test Plan:
- Reset held for 4 clk mid-transfer → SDA = 'bz; busy, addr_match, rx_valid = 0; state IDLE; the next START is decoded correctly.
- Master writes addr 0x50, W, data 0xA5 → ACK (SDA = 0) on both 9th clocks; rx_valid pulses once with rx_data = 0xA5; addr_match = 1; busy drops 3 clk after STOP.
- Master addresses 0x51 → no ACK (SDA = 'bz in the 9th clock); state WAIT_STOP; no rx_valid or tx_load pulses.
- Master reads from 0x50 with tx_data = 0x3C → bits 0,0,1,1,1,1,0,0 on SDA; tx_load pulses once; master NACK → WAIT_STOP, SDA released.
- Write of 3 bytes 0x01, 0x02, 0x03 → three rx_valid pulses in order, each byte ACKed.
- Repeated START:
  - Sequence: write 0x50 with byte 0x11, then repeated START, then read 0x50 with tx_data = 0xF0.
  - Required: rx_data = 0x11, followed by a read returning 0xF0.
  - Required: busy stays high throughout, and addr_match drops for the address phase of the read.
